// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and receive-FSM state type.
// The output generator reuses the same constants so both ends agree on
// the expected raster.
package vga_timing_pkg;

    localparam int CNT_W = 12;   // width of every measurement counter
    localparam int POS_W = 10;   // width of regenerated x / y

    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_H_SYNC_START = 656;
    localparam int VGA_H_SYNC_W     = 96;
    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_TOTAL      = 525;
    localparam int VGA_V_SYNC_START = 490;
    localparam int VGA_V_SYNC_W     = 2;
    localparam int VGA_LOCK_FRAMES  = 2;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/vga_timing_rx_sync_edge.sv
// sync_edge: 2-flop synchronizer followed by one edge-detect register.
// Ports:
//   pclk, rst  - clock, synchronous active-high reset
//   din        - asynchronous input
//   fall, rise - single-cycle pulses on a synchronized 1->0 / 0->1 change
module sync_edge (
    input  logic pclk,
    input  logic rst,
    input  logic din,
    output logic fall,
    output logic rise
);

    logic meta, sync, sync_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_q <= sync;
        end
    end

    // Pulses are consumed by registers in the parent, so the resulting
    // state change lands on the third edge after the pin moves.
    assign fall = sync_q & ~sync;
    assign rise = ~sync_q & sync;

endmodule

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: measures incoming VGA sync timing, declares lock once the
// raster is stable and regenerates x / y / de / frame_start from it.
// Ports:
//   pclk, rst          - pixel clock, synchronous active-high reset
//   vga_hs, vga_vs     - active-low syncs, asynchronous to pclk
//   h_total, h_sync_w  - last line period / hsync low width (pclk cycles)
//   v_total, v_sync_w  - last frame length / vsync low width (lines)
//   locked             - timing stable
//   mode_ok            - locked and all measurements match the parameters
//   x, y, de           - regenerated position and active-video enable
//   frame_start        - one-cycle pulse at x=0, y=0 while locked
module vga_timing_rx
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int H_SYNC_START = VGA_H_SYNC_START,
    parameter int H_SYNC_W     = VGA_H_SYNC_W,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_TOTAL      = VGA_V_TOTAL,
    parameter int V_SYNC_START = VGA_V_SYNC_START,
    parameter int V_SYNC_W     = VGA_V_SYNC_W,
    parameter int LOCK_FRAMES  = VGA_LOCK_FRAMES
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vga_hs,
    input  logic             vga_vs,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_sync_w,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_sync_w,
    output logic             locked,
    output logic             mode_ok,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic             de,
    output logic             frame_start
);

    localparam int MATCH_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic hs_fall, hs_rise, vs_fall, vs_rise;

    sync_edge u_hs (.pclk(pclk), .rst(rst), .din(vga_hs), .fall(hs_fall), .rise(hs_rise));
    sync_edge u_vs (.pclk(pclk), .rst(rst), .din(vga_vs), .fall(vs_fall), .rise(vs_rise));

    logic [CNT_W-1:0]   hcnt, lcnt;
    logic               line_err;
    logic [MATCH_W-1:0] match, match_nxt;
    rx_state_e          state, state_nxt;
    logic [POS_W-1:0]   hpos, vpos;

    logic h_mis, v_mis, timeout, frame_ok, hwrap;

    // Compare against the previous measurement, which is still held in
    // the output register on the cycle the new value is captured.
    assign h_mis    = hs_fall & (hcnt != h_total);
    assign v_mis    = vs_fall & (lcnt != v_total);
    assign timeout  = (hcnt == CNT_MAX);
    assign frame_ok = ~line_err & ~h_mis & ~v_mis;
    assign hwrap    = (hpos >= POS_W'(H_TOTAL - 1));

    always_comb begin
        state_nxt = state;
        match_nxt = match;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nxt = MEASURE;
                    match_nxt = '0;
                end
            end
            MEASURE: begin
                if (vs_fall) begin
                    if (!frame_ok) begin
                        match_nxt = '0;
                    end else if (match == MATCH_W'(LOCK_FRAMES - 1)) begin
                        state_nxt = LOCKED;
                        match_nxt = '0;
                    end else begin
                        match_nxt = match + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (h_mis || v_mis || timeout) state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Measurement, stability tracking and FSM state.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcnt     <= '0;
            lcnt     <= '0;
            h_total  <= '0;
            h_sync_w <= '0;
            v_total  <= '0;
            v_sync_w <= '0;
            line_err <= 1'b0;
            match    <= '0;
            state    <= SEARCH;
            locked   <= 1'b0;
            mode_ok  <= 1'b0;
        end else begin
            if (hs_fall) begin
                hcnt    <= CNT_W'(1);
                h_total <= hcnt;
            end else if (hcnt != CNT_MAX) begin
                hcnt <= hcnt + 1'b1;
            end
            if (hs_rise) h_sync_w <= hcnt;

            // A line whose hs_fall lands on vs_fall belongs to the new frame.
            if (vs_fall) begin
                v_total <= lcnt;
                lcnt    <= CNT_W'(hs_fall);
            end else if (hs_fall && lcnt != CNT_MAX) begin
                lcnt <= lcnt + 1'b1;
            end
            if (vs_rise) v_sync_w <= lcnt;

            if (vs_fall)                line_err <= 1'b0;
            else if (h_mis || timeout)  line_err <= 1'b1;

            state   <= state_nxt;
            match   <= match_nxt;
            locked  <= (state_nxt == LOCKED);
            mode_ok <= locked
                     & (h_total  == CNT_W'(H_TOTAL))
                     & (h_sync_w == CNT_W'(H_SYNC_W))
                     & (v_total  == CNT_W'(V_TOTAL))
                     & (v_sync_w == CNT_W'(V_SYNC_W));
        end
    end

    // Position regeneration runs in every state so x / y stay meaningful
    // while lock is being acquired; only de / frame_start are gated.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hpos        <= '0;
            vpos        <= '0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (hs_fall)    hpos <= POS_W'(H_SYNC_START);
            else if (hwrap) hpos <= '0;
            else            hpos <= hpos + 1'b1;

            // The vsync load outranks a coincident line wrap.
            if (vs_fall)
                vpos <= POS_W'(V_SYNC_START);
            else if (hwrap)
                vpos <= (vpos >= POS_W'(V_TOTAL - 1)) ? '0 : vpos + 1'b1;

            x           <= hpos;
            y           <= vpos;
            de          <= locked & (hpos < POS_W'(H_ACTIVE)) & (vpos < POS_W'(V_ACTIVE));
            frame_start <= locked & (hpos == '0) & (vpos == '0);
        end
    end

endmodule
